simple_pipeline_dut: RTL and testbench

//  Five-stage in-order pipeline skeleton: IF, ID, EX, MEM, WB for a MIPS-subset datapath.

---
 rtl/simple_pipeline_dut_if.sv | 17 +
 rtl/simple_pipeline_dut.sv | 273 +++++++++++++++++++++++++++
 tb/tb_simple_pipeline_dut.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_pipeline_dut_if.sv
// Instruction/result bundle for the pipeline core.
// The master side presents instruction words and observes the write-back
// value; the core itself connects through the slave side.
interface simple_pipeline_dut_if;
   logic [31:0] instruction_in;
   logic [31:0] result_out;

   modport master (
      output instruction_in,
      input  result_out
   );

   modport slave (
      input  instruction_in,
      output result_out
   );
endinterface

// File: rtl/simple_pipeline_dut.sv
// Five-stage in-order pipeline skeleton (IF, ID, EX, MEM, WB) for a small
// MIPS subset. Instruction and data memories sit outside this block; the
// MEM stage only carries its control bits along with the result.
module simple_pipeline_dut #(
   parameter int unsigned CTRL_HOLD_CYCLES = 0
) (
   input logic                  clk,
   input logic                  reset,
   simple_pipeline_dut_if.slave bus
);

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_SB      = 6'b101000;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;

   typedef enum logic {
      CTRL_HOLD,
      CTRL_RUN
   } ctrl_state_t;

   ctrl_state_t ctrl_state;
   ctrl_state_t ctrl_state_next;
   logic [31:0] hold_count;
   logic [31:0] hold_count_next;
   logic        ctrl_sel;

   logic [31:0] pc_reg;
   logic [31:0] npc_reg;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [5:0]  funct;
   logic [14:0] decoded_ctrl;
   logic [14:0] control_bus;
   logic [4:0]  decoded_dest;
   logic [31:0] rs_value;
   logic [31:0] rt_value;

   logic [31:0] regfile [0:31];

   logic [14:0] idex_ctrl;
   logic [31:0] idex_rs_value;
   logic [31:0] idex_rt_value;
   logic [31:0] idex_imm_ext;
   logic [4:0]  idex_dest;
   logic [31:0] idex_pc8;

   logic [31:0] operand2;
   logic [31:0] alu_result;
   logic [31:0] ex_result;

   logic [2:0]  alu_op_reg;
   logic        load_reg;
   logic        branch_reg;
   logic        ta_reg;
   logic [1:0]  mem_size_reg;
   logic        mem_rw_reg;
   logic        mem_se_reg;
   logic        mem_enable_reg;
   logic        exmem_rf_enable;
   logic        exmem_hi_enable;
   logic        exmem_lo_enable;
   logic [4:0]  exmem_dest;
   logic [31:0] exmem_result;

   logic [31:0] result_reg;
   logic        rf_enable_reg;
   logic        hi_enable_reg;
   logic        lo_enable_reg;
   logic [4:0]  wb_dest;

   assign bus.result_out = result_reg;

   // Control-mux state register: counts edges after reset until the hold expires
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_state <= CTRL_HOLD;
         hold_count <= 32'd0;
      end else begin
         ctrl_state <= ctrl_state_next;
         hold_count <= hold_count_next;
      end
   end

   // Leave the hold state on the edge that completes the hold window; the
   // +1 makes a zero hold release on the very first edge
   always_comb begin
      ctrl_state_next = ctrl_state;
      hold_count_next = hold_count;
      ctrl_sel        = 1'b0;
      case (ctrl_state)
         CTRL_HOLD: begin
            if ((hold_count + 32'd1) >= CTRL_HOLD_CYCLES) begin
               ctrl_state_next = CTRL_RUN;
            end else begin
               hold_count_next = hold_count + 32'd1;
            end
         end
         CTRL_RUN: begin
            ctrl_sel = 1'b1;
         end
         default: begin
            ctrl_state_next = CTRL_HOLD;
         end
      endcase
   end

   // Fetch: PC advances unconditionally, instruction word and its PC are latched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg   <= 32'd0;
         npc_reg  <= 32'd4;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
      end else begin
         pc_reg   <= npc_reg;
         npc_reg  <= npc_reg + 32'd4;
         if_instr <= bus.instruction_in;
         if_pc    <= pc_reg;
      end
   end

   assign op    = if_instr[31:26];
   assign rs    = if_instr[25:21];
   assign rt    = if_instr[20:16];
   assign rd    = if_instr[15:11];
   assign imm   = if_instr[15:0];
   assign funct = if_instr[5:0];

   assign rs_value = (rs == 5'd0) ? 32'd0 : regfile[rs];
   assign rt_value = (rt == 5'd0) ? 32'd0 : regfile[rt];

   // Decode the opcode into the control bus and pick the write-back register
   always_comb begin
      decoded_ctrl = '0;
      decoded_ctrl[14] = (op == OP_ADDIU) || (op == OP_LUI) || (op == OP_LBU) || (op == OP_SB);
      if (op == OP_ADDIU) begin
         decoded_ctrl[13:11] = 3'b001;
      end else if ((op == OP_RTYPE) && (funct == FUNCT_SUBU)) begin
         decoded_ctrl[13:11] = 3'b010;
      end else if (op == OP_LUI) begin
         decoded_ctrl[13:11] = 3'b011;
      end
      decoded_ctrl[10]  = (op == OP_LBU);
      decoded_ctrl[9]   = (op == OP_RTYPE) || (op == OP_ADDIU) || (op == OP_LUI) || (op == OP_LBU) || (op == OP_JAL);
      decoded_ctrl[8]   = (op == OP_BGTZ);
      decoded_ctrl[7]   = (op == OP_JAL);
      decoded_ctrl[6:5] = (op == OP_ADDIU) ? 2'b01 : 2'b00;
      decoded_ctrl[4]   = (op == OP_SB);
      decoded_ctrl[3]   = (op == OP_LBU);
      decoded_ctrl[2]   = (op == OP_RTYPE);
      decoded_ctrl[1]   = (op == OP_RTYPE);
      decoded_ctrl[0]   = (op == OP_SB);

      if (op == OP_JAL) begin
         decoded_dest = 5'd31;
      end else if (op == OP_RTYPE) begin
         decoded_dest = rd;
      end else begin
         decoded_dest = rt;
      end
   end

   assign control_bus = ctrl_sel ? decoded_ctrl : 15'd0;

   // ID/EX register: a bubble is a fully zeroed entry so it produces a 0 result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_ctrl     <= '0;
         idex_rs_value <= '0;
         idex_rt_value <= '0;
         idex_imm_ext  <= '0;
         idex_dest     <= '0;
         idex_pc8      <= '0;
      end else if (ctrl_sel) begin
         idex_ctrl     <= control_bus;
         idex_rs_value <= rs_value;
         idex_rt_value <= rt_value;
         idex_imm_ext  <= {{16{imm[15]}}, imm};
         idex_dest     <= decoded_dest;
         idex_pc8      <= if_pc + 32'd8;
      end else begin
         idex_ctrl     <= '0;
         idex_rs_value <= '0;
         idex_rt_value <= '0;
         idex_imm_ext  <= '0;
         idex_dest     <= '0;
         idex_pc8      <= '0;
      end
   end

   // Execute: select operand, run the ALU, and let jump-and-link return PC+8
   always_comb begin
      operand2   = idex_ctrl[14] ? idex_imm_ext : idex_rt_value;
      alu_result = 32'd0;
      case (idex_ctrl[13:11])
         3'b000:  alu_result = idex_rs_value + operand2;
         3'b001:  alu_result = idex_rs_value + operand2;
         3'b010:  alu_result = idex_rs_value - operand2;
         3'b011:  alu_result = {idex_imm_ext[15:0], 16'h0000};
         default: alu_result = 32'd0;
      endcase
      ex_result = idex_ctrl[7] ? idex_pc8 : alu_result;
   end

   // EX/MEM register: result plus the control fields the later stages carry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_op_reg      <= '0;
         load_reg        <= 1'b0;
         branch_reg      <= 1'b0;
         ta_reg          <= 1'b0;
         mem_size_reg    <= '0;
         mem_rw_reg      <= 1'b0;
         mem_se_reg      <= 1'b0;
         mem_enable_reg  <= 1'b0;
         exmem_rf_enable <= 1'b0;
         exmem_hi_enable <= 1'b0;
         exmem_lo_enable <= 1'b0;
         exmem_dest      <= '0;
         exmem_result    <= '0;
      end else begin
         alu_op_reg      <= idex_ctrl[13:11];
         load_reg        <= idex_ctrl[10];
         branch_reg      <= idex_ctrl[8];
         ta_reg          <= idex_ctrl[7];
         mem_size_reg    <= idex_ctrl[6:5];
         mem_rw_reg      <= idex_ctrl[4];
         mem_se_reg      <= idex_ctrl[3];
         mem_enable_reg  <= idex_ctrl[0];
         exmem_rf_enable <= idex_ctrl[9];
         exmem_hi_enable <= idex_ctrl[2];
         exmem_lo_enable <= idex_ctrl[1];
         exmem_dest      <= idex_dest;
         exmem_result    <= ex_result;
      end
   end

   // MEM/WB register: no data memory, so the result passes straight through
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_reg    <= '0;
         rf_enable_reg <= 1'b0;
         hi_enable_reg <= 1'b0;
         lo_enable_reg <= 1'b0;
         wb_dest       <= '0;
      end else begin
         result_reg    <= exmem_result;
         rf_enable_reg <= exmem_rf_enable;
         hi_enable_reg <= exmem_hi_enable;
         lo_enable_reg <= exmem_lo_enable;
         wb_dest       <= exmem_dest;
      end
   end

   // Write-back into the register file; contents survive reset and r0 stays 0
   always_ff @(posedge clk) begin
      if (rf_enable_reg && (wb_dest != 5'd0)) begin
         regfile[wb_dest] <= result_reg;
      end
   end

endmodule

// File: tb/tb_simple_pipeline_dut.sv
// Bench for simple_pipeline_dut: decode table, hand-written pipeline
// sequences, a long hold-window instance, and randomized programs compared
// against an instruction-level reference model.
module tb_simple_pipeline_dut;

   logic clk;
   logic reset;
   int   checkCount;
   int   passCount;

   simple_pipeline_dut_if busA ();
   simple_pipeline_dut_if busH ();

   simple_pipeline_dut dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   simple_pipeline_dut #(.CTRL_HOLD_CYCLES(20)) dutHold (
      .clk   (clk),
      .reset (reset),
      .bus   (busH.slave)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] instr;
      logic [14:0] ctrl;
   } decode_vec_t;

   localparam int NUM_VECS   = 9;
   localparam int RAND_COUNT = 200;
   localparam int PROG_LEN   = 31 + 4 + RAND_COUNT + 5;

   decode_vec_t vecs [NUM_VECS];
   logic [31:0] prog     [PROG_LEN];
   logic [31:0] expRes   [PROG_LEN];
   logic [4:0]  expDest  [PROG_LEN];
   logic        expWen   [PROG_LEN];
   logic [31:0] modelRegs [32];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] instr);
      busA.instruction_in = instr;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      @(posedge clk);
      #2;
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
   endtask

   // Instruction-level semantics of the subset, independent of pipeline timing
   function automatic void modelExec(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic [4:0] dest, output logic wen);
      logic [31:0] simm;
      simm = {{16{instr[15]}}, instr[15:0]};
      res  = a + b;
      dest = instr[20:16];
      wen  = 1'b0;
      case (instr[31:26])
         6'h00: begin
            wen  = 1'b1;
            dest = instr[15:11];
            res  = (instr[5:0] == 6'h23) ? (a - b) : (a + b);
         end
         6'h09: begin
            wen = 1'b1;
            res = a + simm;
         end
         6'h0F: begin
            wen = 1'b1;
            res = {instr[15:0], 16'h0000};
         end
         6'h24: begin
            wen = 1'b1;
            res = a + simm;
         end
         6'h28: begin
            res = a + simm;
         end
         6'h03: begin
            wen  = 1'b1;
            dest = 5'd31;
            res  = pc + 32'd8;
         end
         default: begin
            res = a + b;
         end
      endcase
   endfunction

   function automatic logic [31:0] randomInstr();
      logic [31:0] f;
      logic [5:0]  rop;
      logic [31:0] ins;
      f   = $urandom;
      rop = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 7))
         0:       ins = {6'h00, f[25:11], 5'd0, 6'h23};
         1:       ins = {6'h00, f[25:0]};
         2:       ins = {6'h09, f[25:0]};
         3:       ins = {6'h0F, f[25:0]};
         4:       ins = {6'h24, f[25:0]};
         5:       ins = {6'h28, f[25:0]};
         6:       ins = {6'h03, f[25:0]};
         default: ins = {rop, f[25:0]};
      endcase
      return ins;
   endfunction

   initial begin
      logic [31:0] seq4 [10];
      logic [31:0] seq5 [7];
      logic [31:0] seq6 [10];
      logic [31:0] a;
      logic [31:0] b;

      checkCount = 0;
      passCount  = 0;
      reset      = 1'b0;
      busA.instruction_in = 32'd0;
      busH.instruction_in = 32'h24050007;

      vecs[0] = '{instr: 32'h24050007, ctrl: 15'h4A20};
      vecs[1] = '{instr: 32'h3C021234, ctrl: 15'h5A00};
      vecs[2] = '{instr: 32'h90000000, ctrl: 15'h4608};
      vecs[3] = '{instr: 32'hA0000000, ctrl: 15'h4011};
      vecs[4] = '{instr: 32'h00451823, ctrl: 15'h1206};
      vecs[5] = '{instr: 32'h00451821, ctrl: 15'h0206};
      vecs[6] = '{instr: 32'h0C000000, ctrl: 15'h0280};
      vecs[7] = '{instr: 32'h1C000000, ctrl: 15'h0100};
      vecs[8] = '{instr: 32'h10000000, ctrl: 15'h0000};

      // Reset state and free-running PC
      resetDut();
      checkOutput("reset_pc", dut.pc_reg, 32'd0);
      checkOutput("reset_npc", dut.npc_reg, 32'd4);
      checkOutput("reset_result", busA.result_out, 32'd0);
      applyStimulus(32'd0);
      applyStimulus(32'd0);
      applyStimulus(32'd0);
      checkOutput("pc_after3", dut.pc_reg, 32'd12);
      checkOutput("npc_after3", dut.npc_reg, 32'd16);

      // Decode table
      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].instr);
         checkOutput($sformatf("decode_%0d", i), {17'd0, dut.control_bus}, {17'd0, vecs[i].ctrl});
      end

      // Held ADDIU r5,r0,7
      resetDut();
      for (int e = 1; e <= 5; e++) begin
         applyStimulus(32'h24050007);
         if (e == 1) checkOutput("addiu_ctrl", {17'd0, dut.control_bus}, 32'h00004A20);
         if (e == 3) checkOutput("addiu_early", busA.result_out, 32'd0);
         if (e == 4) checkOutput("addiu_result", busA.result_out, 32'd7);
         if (e == 5) checkOutput("addiu_r5", dut.regfile[5], 32'd7);
      end

      // Hold window of 20 edges on the second instance
      resetDut();
      for (int e = 1; e <= 30; e++) begin
         applyStimulus(32'd0);
         checkOutput($sformatf("hold_result_e%0d", e), busH.result_out, (e >= 23) ? 32'd7 : 32'd0);
         if (e == 19) checkOutput("hold_ctrl_e19", {17'd0, dutHold.control_bus}, 32'd0);
         if (e == 20) checkOutput("hold_ctrl_e20", {17'd0, dutHold.control_bus}, 32'h00004A20);
      end

      // LUI, ADDIU, then SUBU once both writes have landed
      seq4[0] = 32'h3C021234;
      seq4[1] = 32'h24050007;
      seq4[2] = 32'd0;
      seq4[3] = 32'd0;
      seq4[4] = 32'd0;
      seq4[5] = 32'h00451823;
      seq4[6] = 32'd0;
      seq4[7] = 32'd0;
      seq4[8] = 32'd0;
      seq4[9] = 32'd0;
      resetDut();
      for (int e = 1; e <= 10; e++) begin
         applyStimulus(seq4[e-1]);
         if (e == 4) checkOutput("lui_result", busA.result_out, 32'h12340000);
         if (e == 5) checkOutput("addiu_r5_result", busA.result_out, 32'd7);
         if (e == 6) checkOutput("lui_r2", dut.regfile[2], 32'h12340000);
         if (e == 9) checkOutput("subu_result", busA.result_out, 32'h1233FFF9);
         if (e == 10) checkOutput("subu_r3", dut.regfile[3], 32'h1233FFF9);
      end

      // JAL fetched while PC=8
      seq5[0] = 32'd0;
      seq5[1] = 32'd0;
      seq5[2] = 32'h0C000000;
      seq5[3] = 32'd0;
      seq5[4] = 32'd0;
      seq5[5] = 32'd0;
      seq5[6] = 32'd0;
      resetDut();
      for (int e = 1; e <= 7; e++) begin
         applyStimulus(seq5[e-1]);
         if (e == 3) checkOutput("jal_ctrl", {17'd0, dut.control_bus}, 32'h00000280);
         if (e == 6) checkOutput("jal_result", busA.result_out, 32'd16);
         if (e == 7) checkOutput("jal_r31", dut.regfile[31], 32'd16);
      end

      // SB must not touch its rt register
      seq6[0] = 32'h24070055;
      seq6[1] = 32'd0;
      seq6[2] = 32'd0;
      seq6[3] = 32'd0;
      seq6[4] = 32'hA0070005;
      seq6[5] = 32'd0;
      seq6[6] = 32'd0;
      seq6[7] = 32'd0;
      seq6[8] = 32'd0;
      seq6[9] = 32'd0;
      resetDut();
      for (int e = 1; e <= 10; e++) begin
         applyStimulus(seq6[e-1]);
         if (e == 5) checkOutput("sb_ctrl", {17'd0, dut.control_bus}, 32'h00004011);
         if (e == 8) checkOutput("sb_result", busA.result_out, 32'd5);
         if (e == 10) checkOutput("sb_r7_kept", dut.regfile[7], 32'h00000055);
      end

      // Asynchronous reset in the middle of a stream of ADDIUs
      for (int e = 1; e <= 6; e++) begin
         applyStimulus(32'h24060009);
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_result", busA.result_out, 32'd0);
      checkOutput("midreset_pc", dut.pc_reg, 32'd0);
      checkOutput("midreset_npc", dut.npc_reg, 32'd4);
      checkOutput("midreset_ifid", dut.if_instr, 32'd0);
      checkOutput("midreset_idex", {17'd0, dut.idex_ctrl}, 32'd0);
      checkOutput("midreset_exmem", dut.exmem_result, 32'd0);
      checkOutput("midreset_wben", {31'd0, dut.rf_enable_reg}, 32'd0);

      // Randomized program: prologue fills every register, then random ops
      for (int r = 1; r <= 31; r++) begin
         prog[r-1] = {6'h09, 5'd0, 5'(r), 16'($urandom)};
      end
      for (int i = 31; i < PROG_LEN; i++) begin
         prog[i] = 32'd0;
      end
      for (int i = 35; i < 35 + RAND_COUNT; i++) begin
         prog[i] = randomInstr();
      end
      for (int r = 0; r < 32; r++) begin
         modelRegs[r] = 32'd0;
      end
      for (int i = 0; i < PROG_LEN; i++) begin
         if (i >= 4 && expWen[i-4] && expDest[i-4] != 5'd0) begin
            modelRegs[expDest[i-4]] = expRes[i-4];
         end
         a = modelRegs[prog[i][25:21]];
         b = modelRegs[prog[i][20:16]];
         modelExec(prog[i], 32'(4 * i), a, b, expRes[i], expDest[i], expWen[i]);
      end
      for (int i = PROG_LEN - 4; i < PROG_LEN; i++) begin
         if (expWen[i] && expDest[i] != 5'd0) begin
            modelRegs[expDest[i]] = expRes[i];
         end
      end

      resetDut();
      for (int e = 1; e <= PROG_LEN + 4; e++) begin
         applyStimulus((e <= PROG_LEN) ? prog[e-1] : 32'd0);
         if (e >= 4 && e <= PROG_LEN + 3) begin
            checkOutput($sformatf("rand_result_%0d", e - 4), busA.result_out, expRes[e-4]);
         end
      end
      for (int r = 1; r < 32; r++) begin
         checkOutput($sformatf("rand_reg_r%0d", r), dut.regfile[r], modelRegs[r]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
